write_buffered: RTL and testbench
=================================

# write_buffered

Parametrised write-back stage with a posted-store buffer. It sits at the end of the pipeline, after execute and before fetch. It commits register results every valid cycle and queues memory stores in a DEPTH-entry FIFO that drains to memory independently. The pipeline stalls only when the buffer is full or a fence is pending. It also gives store-to-load forwarding and buffer status back to earlier stages.

## Interface
- NR, 32, number of architectural registers
- W, 32, register/data width
- DEPTH, 4, store buffer entries (power of two, ≥2)
- FLAGS_IDX, NR-2, index of the flags register; bits [W-2:W-6] take `flags`
- PC_IDX, NR-1, index of the program counter
- clock  in  1  single clock; all state changes on posedge
- reset_n  in  1  synchronous, active-low reset
- is_valid  in  1  flow control: current instruction is valid
- hold  out  1  flow control: stall upstream this cycle
- target_register, address_register  in  $clog2(NR)  destination / store base register
- target_value, upper_value, adjustment_value, pc, next_pc  in  W  execute results
- has_upper_value, is_writing_memory, is_fence, has_flushed_in  in  1  instruction qualifiers
- flags  in  5  new flag bits
- input_registers  in  NR*W  current register file
- output_registers  out  NR*W  committed register file
- has_flushed  out  1  registered has_flushed_in & is_valid
- address_enable  out  1  buffer head valid; memory write request
- address, data  out  W  buffer head address/data
- data_valid  in  1  memory accepts the head write
- lookup_address  in  W  load address from an earlier stage
- lookup_hit  out  1  some buffered store matches lookup_address
- lookup_data  out  W  data of the youngest matching store
- store_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Register update when is_valid and not holding:
  - Register 0 always reads 0.
  - If not is_writing_memory, reg[target_register] gets target_value.
  - If has_upper_value and not is_writing_memory, reg[target_register+1] gets upper_value.
  - If has_upper_value and is_writing_memory, reg[target_register] gets upper_value. This is the post-increment base writeback.
  - FLAGS_IDX, when not written explicitly, keeps bit W-1 and bits [W-7:0] and takes `flags` in [W-2:W-6].
- PC: output_registers[PC_IDX] is written every non-reset cycle, including invalid cycles.
  - It takes target_value or upper_value when PC is the written target under the rules above.
  - Otherwise it takes next_pc.
  - When held, it keeps its value.
- Store push: is_valid & is_writing_memory & !hold pushes {address = reg[address_register] + adjustment_value (mod 2^W), data = target_value}.
  - The address is computed from the registers before this cycle's update.
  - The base register reads pc when address_register == PC_IDX.
- Drain: address_enable = (count != 0), with the head's address and data.
  - data_valid while address_enable is high pops the head.
  - data_valid while the buffer is empty is ignored.
- Hold (combinational) is asserted when reset_n is high, is_valid is high, and either of these holds:
  - a store arrives while count == DEPTH and no pop occurs this cycle;
  - is_fence is set and the buffer is not empty, or is empty only because of a pop this cycle. In other words, the fence completes in the first cycle it sees count == 0.
- While held, nothing is pushed or committed and has_flushed is 0.
- Forwarding: lookup_hit and lookup_data are combinational over the occupied entries; the youngest match wins. The entry being popped this cycle still participates.
- Pointers wrap modulo DEPTH. count goes from 0 to DEPTH.

## Timing
- Reset (sampled low at posedge) sets:
  - output_registers = 0, pointers = 0, count = 0, has_flushed = 0;
  - address_enable = 0, lookup_hit = 0, store_count = 0;
  - address, data and lookup_data = 0.
  - This discards any buffered stores mid-drain. hold = 0 while reset_n is low.
- Register results are visible on output_registers one cycle after the valid cycle.
- A store pushed into an empty buffer at edge N raises address_enable at N+1. The minimum occupancy is 1 cycle per entry, with data_valid same-cycle.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted and hold = 0.
  - When count == 1, the popped entry leaves and the new entry becomes head the next cycle.
- A newly pushed store is not visible to lookup until the next cycle.
- Throughput is one instruction per cycle while count < DEPTH.

## Test plan
- Reset mid-drain with 3 entries queued → next cycle count = 0, address_enable = 0, and no pop is caused by a late data_valid.
- ALU writes r5 = 0x1234 then r6/r7 pair (0xA, 0xB) → r5, r6, r7 updated one cycle later each; the PC register follows next_pc.
- 5 stores with DEPTH = 4 and data_valid held low → hold asserted on the 5th. Raise data_valid for one cycle → 5th accepted, count stays 4.
- Store 0xAA to 0x100, then 0xBB to 0x100, with memory stalled; lookup 0x100 → hit = 1, data = 0xBB. Lookup 0x104 → hit = 0.
- Fence with 2 entries, data_valid every cycle → hold for 2 cycles, released in the cycle count reaches 0.
- Post-increment store: base r3 = 0x200, adj 4, upper 0x204 → memory address 0x204, r3 = 0x204 afterward; base wrap 0xFFFFFFFC + 8 → address 0x4.

Source files
------------

// File: rtl/write_buffered_if.sv
// rtl/write_buffered_if.sv - memory drain bus between the posted-store buffer and memory
interface write_buffered_if #(
    parameter int W = 32
);
    logic         address_enable;
    logic [W-1:0] address;
    logic [W-1:0] data;
    logic         data_valid;

    modport master (output address_enable, address, data, input data_valid);
    modport slave  (input address_enable, address, data, output data_valid);
endinterface

// File: rtl/write_buffered.sv
// rtl/write_buffered.sv - write-back stage with register commit and DEPTH-entry posted-store buffer
module write_buffered #(
    parameter int NR        = 32,
    parameter int W         = 32,
    parameter int DEPTH     = 4,
    parameter int FLAGS_IDX = NR - 2,
    parameter int PC_IDX    = NR - 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    is_valid,
    output logic                    hold,
    input  logic [$clog2(NR)-1:0]   target_register,
    input  logic [$clog2(NR)-1:0]   address_register,
    input  logic [W-1:0]            target_value,
    input  logic [W-1:0]            upper_value,
    input  logic [W-1:0]            adjustment_value,
    input  logic [W-1:0]            pc,
    input  logic [W-1:0]            next_pc,
    input  logic                    has_upper_value,
    input  logic                    is_writing_memory,
    input  logic                    is_fence,
    input  logic                    has_flushed_in,
    input  logic [4:0]              flags,
    input  logic [NR*W-1:0]         input_registers,
    output logic [NR*W-1:0]         output_registers,
    output logic                    has_flushed,
    write_buffered_if.master        mem,
    input  logic [W-1:0]            lookup_address,
    output logic                    lookup_hit,
    output logic [W-1:0]            lookup_data,
    output logic [$clog2(DEPTH):0]  store_count
);
    localparam int AW = $clog2(NR);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NR-1:0][W-1:0]    regs_q, regs_d, regs_in;
    logic [DEPTH-1:0][W-1:0] addr_q, addr_d, data_q, data_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, lk_idx;
    logic [CW-1:0]           count_q, count_d;
    logic                    has_flushed_q, has_flushed_d;
    logic                    commit, push, pop, full, wr_lo, wr_hi, pc_explicit;
    logic [AW-1:0]           tgt_hi;
    logic [W-1:0]            lo_val, base, push_addr;

    assign regs_in   = input_registers;
    assign tgt_hi    = target_register + AW'(1);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = mem.data_valid && (count_q != '0);

    // A pop frees the full slot in the same cycle; a fence waits for a genuinely empty buffer.
    always_comb begin
        hold = 1'b0;
        if (reset_n && is_valid) begin
            if (is_writing_memory && full && !pop) hold = 1'b1;
            if (is_fence && (count_q != '0))       hold = 1'b1;
        end
    end

    assign commit      = is_valid && !hold;
    assign push        = commit && is_writing_memory;
    assign wr_lo       = commit && (!is_writing_memory || has_upper_value);
    assign wr_hi       = commit && !is_writing_memory && has_upper_value;
    assign lo_val      = is_writing_memory ? upper_value : target_value;
    assign pc_explicit = (wr_lo && (target_register == AW'(PC_IDX))) ||
                         (wr_hi && (tgt_hi == AW'(PC_IDX)));
    assign base        = (address_register == AW'(PC_IDX)) ? pc : regs_in[address_register];
    assign push_addr   = base + adjustment_value;

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d = regs_in;
            regs_d[FLAGS_IDX][W-2 -: 5] = flags;
            if (wr_lo) regs_d[target_register] = lo_val;
            if (wr_hi) regs_d[tgt_hi] = upper_value;
        end
        if (!hold && !pc_explicit) regs_d[PC_IDX] = next_pc;
        regs_d[0] = '0;
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = target_value;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
    end

    assign has_flushed_d = has_flushed_in && commit;

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[lk_idx] == lookup_address)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[lk_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs_q        <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            has_flushed_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            has_flushed_q <= has_flushed_d;
        end
    end

    assign output_registers   = regs_q;
    assign has_flushed        = has_flushed_q;
    assign store_count        = count_q;
    assign mem.address_enable = (count_q != '0);
    assign mem.address        = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
    assign mem.data           = (count_q != '0) ? data_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_write_buffered.sv
// tb/tb_write_buffered.sv - scoreboard bench for write_buffered
module tb_write_buffered;
    localparam int NR = 32;
    localparam int W  = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          is_valid, hold;
    logic [4:0]    target_register, address_register;
    logic [31:0]   target_value, upper_value, adjustment_value, pc, next_pc;
    logic          has_upper_value, is_writing_memory, is_fence, has_flushed_in;
    logic [4:0]    flags;
    logic [NR*W-1:0] input_registers, output_registers;
    logic          has_flushed;
    logic [31:0]   lookup_address, lookup_data;
    logic          lookup_hit;
    logic [2:0]    store_count;

    int checks = 0;
    int failures = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    write_buffered_if #(.W(W)) mem_if ();

    write_buffered dut (
        .clock(clock), .reset_n(reset_n), .is_valid(is_valid), .hold(hold),
        .target_register(target_register), .address_register(address_register),
        .target_value(target_value), .upper_value(upper_value),
        .adjustment_value(adjustment_value), .pc(pc), .next_pc(next_pc),
        .has_upper_value(has_upper_value), .is_writing_memory(is_writing_memory),
        .is_fence(is_fence), .has_flushed_in(has_flushed_in), .flags(flags),
        .input_registers(input_registers), .output_registers(output_registers),
        .has_flushed(has_flushed), .mem(mem_if), .lookup_address(lookup_address),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data), .store_count(store_count)
    );

    assign input_registers = output_registers;

    always #5 clock = ~clock;

    function automatic logic [31:0] rd(input int i);
        return output_registers[i*32 +: 32];
    endfunction

    // Memory side: every accepted drain beat must match the oldest expected store.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && mem_if.address_enable === 1'b1 && mem_if.data_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL drain_unexpected addr=%h data=%h required=none", mem_if.address, mem_if.data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_if.address !== mon_e.a || mem_if.data !== mon_e.d) begin
                    failures++;
                    $display("FAIL drain_beat got=%h/%h required=%h/%h",
                             mem_if.address, mem_if.data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        is_valid = 0; target_register = 0; address_register = 0;
        target_value = 0; upper_value = 0; adjustment_value = 0; pc = 0; next_pc = 0;
        has_upper_value = 0; is_writing_memory = 0; is_fence = 0; has_flushed_in = 0;
        flags = 0; lookup_address = 0;
    endtask

    task automatic alu(input logic [4:0] t, input logic [31:0] v);
        idle();
        is_valid = 1; target_register = t; target_value = v;
        tick();
    endtask

    task automatic drive_store(input logic [4:0] ar, input logic [31:0] adj, input logic [31:0] dat);
        idle();
        is_valid = 1; is_writing_memory = 1; address_register = ar;
        adjustment_value = adj; target_value = dat;
    endtask

    task automatic drain;
        int n;
        idle();
        mem_if.data_valid = 1;
        n = 0;
        while (store_count != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (store_count !== 3'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_done count=%0d left=%0d required=0/0", store_count, exp_q.size());
        end
        mem_if.data_valid = 0;
    endtask

    task automatic test_reset;
        idle();
        reset_n = 0; mem_if.data_valid = 0;
        is_valid = 1; is_fence = 1; is_writing_memory = 1;
        tick(); tick();
        checks++;
        if (output_registers !== '0 || store_count !== 3'd0 || mem_if.address_enable !== 1'b0 ||
            hold !== 1'b0 || has_flushed !== 1'b0 || lookup_hit !== 1'b0 ||
            mem_if.address !== 32'd0 || mem_if.data !== 32'd0 || lookup_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_state regs_nz=%0b cnt=%0d ae=%b hold=%b hf=%b hit=%b required all 0",
                     output_registers != '0, store_count, mem_if.address_enable, hold, has_flushed, lookup_hit);
        end
        idle();
        reset_n = 1;
    endtask

    task automatic test_alu;
        idle();
        is_valid = 1; target_register = 5; target_value = 32'h1234; flags = 5'h15; next_pc = 32'h104;
        tick();
        checks++;
        if (rd(5) !== 32'h1234 || rd(31) !== 32'h104 || rd(30) !== 32'h5400_0000) begin
            failures++;
            $display("FAIL alu_r5 r5=%h pc=%h flags=%h required=1234/104/54000000", rd(5), rd(31), rd(30));
        end
        idle();
        is_valid = 1; target_register = 6; target_value = 32'hA; has_upper_value = 1;
        upper_value = 32'hB; next_pc = 32'h108;
        tick();
        checks++;
        if (rd(6) !== 32'hA || rd(7) !== 32'hB || rd(31) !== 32'h108 || rd(30) !== 32'h0) begin
            failures++;
            $display("FAIL alu_pair r6=%h r7=%h pc=%h flags=%h required=a/b/108/0", rd(6), rd(7), rd(31), rd(30));
        end
        alu(30, 32'hFFFF_FFFF);
        checks++;
        if (rd(30) !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL flags_explicit got=%h required=ffffffff", rd(30));
        end
        alu(1, 32'h1);
        checks++;
        if (rd(30) !== 32'h83FF_FFFF) begin
            failures++;
            $display("FAIL flags_merge got=%h required=83ffffff", rd(30));
        end
        idle();
        is_valid = 1; target_register = 31; target_value = 32'h4000; next_pc = 32'h999;
        tick();
        checks++;
        if (rd(31) !== 32'h4000) begin
            failures++;
            $display("FAIL pc_explicit got=%h required=4000", rd(31));
        end
        idle();
        target_register = 5; target_value = 32'hDEAD; next_pc = 32'h10C;
        tick();
        checks++;
        if (rd(31) !== 32'h10C || rd(5) !== 32'h1234) begin
            failures++;
            $display("FAIL invalid_cycle pc=%h r5=%h required=10c/1234", rd(31), rd(5));
        end
        idle();
        is_valid = 1; target_register = 0; target_value = 32'h55; has_flushed_in = 1;
        tick();
        checks++;
        if (rd(0) !== 32'h0 || has_flushed !== 1'b1) begin
            failures++;
            $display("FAIL r0_flush r0=%h hf=%b required=0/1", rd(0), has_flushed);
        end
    endtask

    task automatic test_full;
        wr_t e;
        mem_if.data_valid = 0;
        for (int i = 0; i < 4; i++) begin
            drive_store(5, 32'(i * 4), 32'(i + 1));
            #1;
            checks++;
            if (hold !== 1'b0) begin
                failures++;
                $display("FAIL full_fill_hold i=%0d got=%b required=0", i, hold);
            end
            e.a = 32'h1234 + 32'(i * 4); e.d = 32'(i + 1);
            exp_q.push_back(e);
            tick();
        end
        drive_store(5, 32'h40, 32'h5);
        #1;
        checks++;
        if (hold !== 1'b1 || store_count !== 3'd4 || mem_if.address_enable !== 1'b1) begin
            failures++;
            $display("FAIL full_hold hold=%b cnt=%0d ae=%b required=1/4/1", hold, store_count, mem_if.address_enable);
        end
        tick();
        mem_if.data_valid = 1;
        #1;
        checks++;
        if (hold !== 1'b0 || store_count !== 3'd4) begin
            failures++;
            $display("FAIL full_pushpop hold=%b cnt=%0d required=0/4", hold, store_count);
        end
        e.a = 32'h1274; e.d = 32'h5;
        exp_q.push_back(e);
        tick();
        checks++;
        if (store_count !== 3'd4) begin
            failures++;
            $display("FAIL full_count got=%0d required=4", store_count);
        end
        drain();
    endtask

    task automatic test_forward;
        wr_t e;
        mem_if.data_valid = 0;
        drive_store(0, 32'h100, 32'hAA);
        lookup_address = 32'h100;
        #1;
        checks++;
        if (lookup_hit !== 1'b0) begin
            failures++;
            $display("FAIL fwd_same_cycle hit=%b required=0", lookup_hit);
        end
        e.a = 32'h100; e.d = 32'hAA; exp_q.push_back(e);
        tick();
        drive_store(0, 32'h100, 32'hBB);
        lookup_address = 32'h100;
        #1;
        checks++;
        if (lookup_hit !== 1'b1 || lookup_data !== 32'hAA) begin
            failures++;
            $display("FAIL fwd_first hit=%b data=%h required=1/aa", lookup_hit, lookup_data);
        end
        e.a = 32'h100; e.d = 32'hBB; exp_q.push_back(e);
        tick();
        idle();
        lookup_address = 32'h100;
        #1;
        checks++;
        if (lookup_hit !== 1'b1 || lookup_data !== 32'hBB) begin
            failures++;
            $display("FAIL fwd_youngest hit=%b data=%h required=1/bb", lookup_hit, lookup_data);
        end
        lookup_address = 32'h104;
        #1;
        checks++;
        if (lookup_hit !== 1'b0) begin
            failures++;
            $display("FAIL fwd_miss hit=%b required=0", lookup_hit);
        end
        lookup_address = 32'h100;
        mem_if.data_valid = 1;
        tick();
        #1;
        checks++;
        if (store_count !== 3'd1 || lookup_hit !== 1'b1 || lookup_data !== 32'hBB) begin
            failures++;
            $display("FAIL fwd_popping cnt=%0d hit=%b data=%h required=1/1/bb", store_count, lookup_hit, lookup_data);
        end
        drain();
    endtask

    task automatic test_fence;
        wr_t e;
        mem_if.data_valid = 0;
        for (int i = 0; i < 2; i++) begin
            drive_store(0, 32'h300 + 32'(i * 4), 32'h60 + 32'(i));
            e.a = 32'h300 + 32'(i * 4); e.d = 32'h60 + 32'(i);
            exp_q.push_back(e);
            tick();
        end
        idle();
        is_valid = 1; is_fence = 1; target_register = 8; target_value = 32'h77; has_flushed_in = 1;
        mem_if.data_valid = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (hold !== (c < 2) || store_count !== 3'(2 - c)) begin
                failures++;
                $display("FAIL fence_cycle%0d hold=%b cnt=%0d required=%b/%0d", c, hold, store_count, c < 2, 2 - c);
            end
            tick();
            if (c == 0) begin
                checks++;
                if (rd(8) !== 32'h0 || has_flushed !== 1'b0) begin
                    failures++;
                    $display("FAIL fence_held_commit r8=%h hf=%b required=0/0", rd(8), has_flushed);
                end
            end
        end
        checks++;
        if (rd(8) !== 32'h77 || has_flushed !== 1'b1) begin
            failures++;
            $display("FAIL fence_commit r8=%h hf=%b required=77/1", rd(8), has_flushed);
        end
        mem_if.data_valid = 0;
        idle();
    endtask

    task automatic test_postinc;
        wr_t e;
        mem_if.data_valid = 0;
        alu(3, 32'h200);
        drive_store(3, 32'h4, 32'hDD);
        target_register = 3; has_upper_value = 1; upper_value = 32'h204;
        e.a = 32'h204; e.d = 32'hDD; exp_q.push_back(e);
        tick();
        checks++;
        if (rd(3) !== 32'h204) begin
            failures++;
            $display("FAIL postinc_base got=%h required=204", rd(3));
        end
        alu(9, 32'hFFFF_FFFC);
        drive_store(9, 32'h8, 32'hEE);
        e.a = 32'h4; e.d = 32'hEE; exp_q.push_back(e);
        tick();
        drive_store(31, 32'h10, 32'hCC);
        pc = 32'h1000;
        e.a = 32'h1010; e.d = 32'hCC; exp_q.push_back(e);
        tick();
        drain();
    endtask

    task automatic test_back_to_back;
        wr_t e;
        mem_if.data_valid = 1;
        for (int i = 0; i < 6; i++) begin
            drive_store(0, 32'h500 + 32'(i * 4), 32'h90 + 32'(i));
            #1;
            checks++;
            if (hold !== 1'b0) begin
                failures++;
                $display("FAIL b2b_hold i=%0d got=%b required=0", i, hold);
            end
            e.a = 32'h500 + 32'(i * 4); e.d = 32'h90 + 32'(i); exp_q.push_back(e);
            tick();
            checks++;
            if (store_count !== 3'd1 || mem_if.address !== e.a) begin
                failures++;
                $display("FAIL b2b_head i=%0d cnt=%0d addr=%h required=1/%h", i, store_count, mem_if.address, e.a);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid;
        mem_if.data_valid = 0;
        for (int i = 0; i < 3; i++) begin
            drive_store(0, 32'h700 + 32'(i * 4), 32'h1);
            tick();
        end
        idle();
        reset_n = 0;
        mem_if.data_valid = 1;
        exp_q.delete();
        tick();
        reset_n = 1;
        checks++;
        if (store_count !== 3'd0 || mem_if.address_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid cnt=%0d ae=%b required=0/0", store_count, mem_if.address_enable);
        end
        tick();
        checks++;
        if (store_count !== 3'd0 || mem_if.address_enable !== 1'b0 || output_registers[30*32 +: 32] !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_late cnt=%0d ae=%b required=0/0", store_count, mem_if.address_enable);
        end
        mem_if.data_valid = 0;
    endtask

    initial begin
        mem_if.data_valid = 0;
        reset_n = 0;
        test_reset();
        test_alu();
        test_full();
        test_forward();
        test_fence();
        test_postinc();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
